// File: rtl/mdu_if.sv
// Handshake and result bundle between the decode/pipeline control and the
// multiply/divide sequencer.
//   start, op, a, b         : launch request and operands (master -> slave)
//   busy, done              : sequencer status (slave -> master)
//   hi, lo, div_zero        : result registers (slave -> master)
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer (MULTU/MULT/DIVU/DIV).
// One WIDTH-bit adder/subtractor is reused for WIDTH iterations: shift-add
// for multiply, restoring division for divide. Signs are stripped on launch
// and re-applied in a final fix-up cycle that also loads HI/LO.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active low
//   bus    : mdu_if slave modport
//            start/op/a/b in; busy/done/hi/lo/div_zero out
//            op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  // Control state (reset)
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic             dz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Datapath state (not reset; only meaningful between launch and fix-up)
  logic             is_div;
  logic             sa;
  logic             sb;
  logic             b_zero;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend-then-quotient bits

  logic             launch;
  logic             sa_in;
  logic             sb_in;

  assign launch = (state == IDLE) && bus.start;
  assign sa_in  = bus.a[WIDTH-1] & bus.op[0];
  assign sb_in  = bus.b[WIDTH-1] & bus.op[0];

  // One iteration of the shared adder
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH-1:0]        rem_sh;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        step_hi;
  logic [WIDTH-1:0]        step_lo;

  always_comb begin
    mul_sum = {1'b0, acc_hi};
    if (acc_lo[0]) mul_sum = {1'b0, acc_hi} + {1'b0, mag_b};
    // Remainder never exceeds WIDTH-1 significant bits before the shift,
    // so dropping acc_hi[WIDTH-1] loses nothing.
    rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    diff   = $signed({1'b0, rem_sh}) - $signed({1'b0, mag_b});
    if (is_div) begin
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh;
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (sa ^ sb) prod = neg_2w(prod);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_lo = (sa ^ sb) ? neg_w(acc_lo) : acc_lo;
        fix_hi = sa ? neg_w(acc_hi) : acc_hi;
      end
    end
  end

  // Launch: capture operands as magnitudes / iterate: one adder pass
  always_ff @(posedge clk) begin
    if (launch) begin
      is_div <= bus.op[1];
      sa     <= sa_in;
      sb     <= sb_in;
      a_orig <= bus.a;
      b_zero <= (bus.b == '0);
      mag_b  <= sb_in ? neg_w(bus.b) : bus.b;
      acc_hi <= '0;
      acc_lo <= sa_in ? neg_w(bus.a) : bus.a;
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  // Sequencer control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CALC;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          dz_r   <= is_div & b_zero;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa_l, sb_l, q, r;
    logic [63:0] p;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    edz = 1'b0;
    case (op)
      2'd0: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = 64'(sa_l * sb_l); eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (op == 2'd2) begin
          el = a / b; eh = a % b;
        end else begin
          q = sa_l / sb_l; r = sa_l % sb_l;
          p = 64'(q); el = p[31:0];
          p = 64'(r); eh = p[31:0];
        end
      end
    endcase
  endfunction

  // Drive a request; returns #1 after the accepting edge
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Count edges since the accepting edge (which is edge 1) until done
  task automatic wait_done(input int n0, output int n);
    bit busy_ok;
    busy_ok = 1'b1;
    n = n0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk("busy_during_op", 64'(busy_ok), 64'd1);
    chk("done_seen", 64'(bus.done), 64'd1);
    chk("busy_in_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] eh, input logic [31:0] el, input logic edz);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    chk({tag, "_dz"}, 64'(bus.div_zero), 64'(edz));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int n;
    launch(op, a, b);
    wait_done(1, n);
    chk({tag, "_latency"}, 64'(n), 64'd34);
    check_res(tag, eh, el, edz);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_hold_lo"}, 64'(bus.lo), 64'(el));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t dir [10];

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic        edz;
    logic [1:0]  rop;
    int          n, pulses;
    bit          held_ok;
    logic [31:0] corner [5];

    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

    dir[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    dir[1] = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    dir[2] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    dir[3] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    dir[4] = '{2'd2, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    dir[5] = '{2'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    dir[6] = '{2'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    dir[7] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    dir[8] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    dir[9] = '{2'd1, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};

    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    for (int i = 0; i < 10; i++)
      run_op($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b, dir[i].hi, dir[i].lo, dir[i].dz);

    // Randomized cases against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      model(rop, ra, rb, eh, el, edz);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, eh, el, edz);
    end

    // start held with changing operands while busy: ignored, outputs held
    model(2'd0, 32'h0000_1234, 32'h0000_0010, eh, el, edz);
    ra = bus.hi; rb = bus.lo;
    launch(2'd0, 32'h0000_1234, 32'h0000_0010);
    held_ok = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.op = 2'($urandom_range(0, 3)); bus.a = $urandom; bus.b = $urandom;
      @(posedge clk);
      #1;
      if (bus.hi !== ra || bus.lo !== rb || bus.done !== 1'b0) held_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk("held_outputs_busy", 64'(held_ok), 64'd1);
    wait_done(21, n);
    chk("held_latency", 64'(n), 64'd34);
    check_res("held", eh, el, edz);

    // Back-to-back: launch in the done cycle
    launch(2'd2, 32'd100, 32'd7);
    wait_done(1, n);
    chk("b2b_latency", 64'(n), 64'd34);
    check_res("b2b", 32'd2, 32'd14, 1'b0);

    // Reset mid-operation
    @(posedge clk);
    #1;
    launch(2'd1, 32'hFFFF_0001, 32'h0000_FFFF);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_dz", 64'(bus.div_zero), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    run_op("after_rst", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
